// File: rtl/ovl_delta_cfg_pkg.sv
// ----------------------------------------------------------------------------
// ovl_delta_cfg_pkg
// Shared definitions for the delta-checker configuration loader:
//   - cfg_state_t       : loader FSM state encoding
//   - DEF_*             : default values for the loader parameters
//   - SETTLE_CNT_W      : width of the settle-window counter (holds 1..15)
// ----------------------------------------------------------------------------
package ovl_delta_cfg_pkg;

  typedef enum logic [1:0] {
    WAIT_MIN = 2'd0,
    WAIT_MAX = 2'd1,
    SETTLE   = 2'd2
  } cfg_state_t;

  localparam int DEF_LIMIT_WIDTH   = 8;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_CNT_WIDTH     = 16;

  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/ovl_delta_cfg_settle_ctr.sv
// ----------------------------------------------------------------------------
// ovl_delta_cfg_settle_ctr
// Load / decrement down-counter that times the checker mask window after a
// configuration commit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one (stops at zero)
//   done       : high while the count sits at 1, i.e. the last masked cycle
// ----------------------------------------------------------------------------
module ovl_delta_cfg_settle_ctr
  import ovl_delta_cfg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [SETTLE_CNT_W-1:0] load_val,
  input  logic                    dec,
  output logic                    done
);

  logic [SETTLE_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - SETTLE_CNT_W'(1);
    end
  end

  assign done = (count == SETTLE_CNT_W'(1));

endmodule

// File: rtl/ovl_delta_cfg_loader.sv
// ----------------------------------------------------------------------------
// ovl_delta_cfg_loader
// Loads a (min, max) limit pair for a delta checker over a two-beat
// valid/ready stream, rejects pairs with min > max, masks the checker while
// no configuration is active or a fresh one is settling, and optionally
// counts unmasked checker fires.
//
// Build option:
//   OVL_DELTA_CFG_FIRECNT_EN  defined   -> saturating fire counter present
//                             undefined -> fire_count tied to 0, fire_in and
//                                          fire_clr ignored
//
// Parameters:
//   limit_width   : width of min/max limits
//   settle_cycles : mask length after a commit (1..15)
//   cnt_width     : width of the fire counter
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cfg_valid/ready   : config beat handshake (beat 0 = min, beat 1 = max)
//   cfg_data          : config beat payload
//   min, max          : active limits driven to the checker
//   prevConfigInvalid : checker mask (unset config or settling)
//   cfg_err           : one-cycle pulse on a rejected pair
//   fire_in           : gated checker output
//   fire_clr          : clears the fire counter (priority over increment)
//   fire_count        : saturating count of unmasked fire_in cycles
// ----------------------------------------------------------------------------
module ovl_delta_cfg_loader
  import ovl_delta_cfg_pkg::*;
#(
  parameter int limit_width   = DEF_LIMIT_WIDTH,
  parameter int settle_cycles = DEF_SETTLE_CYCLES,
  parameter int cnt_width     = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  input  logic [limit_width-1:0] cfg_data,
  output logic                   cfg_ready,
  output logic [limit_width-1:0] min,
  output logic [limit_width-1:0] max,
  output logic                   prevConfigInvalid,
  output logic                   cfg_err,
  input  logic                   fire_in,
  input  logic                   fire_clr,
  output logic [cnt_width-1:0]   fire_count
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_INIT = SETTLE_CNT_W'(settle_cycles);

  cfg_state_t             state;
  cfg_state_t             state_nxt;
  logic                   commit;
  logic                   reject;
  logic                   settle_dec;
  logic                   settle_done;
  logic [limit_width-1:0] shadow_min;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_MIN;
    end else begin
      state <= state_nxt;
    end
  end

  // The max beat is validated against the latched min in the cycle it is
  // accepted and written straight into max on commit, so it needs no shadow
  // copy of its own.
  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    commit     = 1'b0;
    reject     = 1'b0;
    settle_dec = 1'b0;
    case (state)
      WAIT_MIN: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_nxt = WAIT_MAX;
        end
      end
      WAIT_MAX: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (shadow_min <= cfg_data) begin
            commit    = 1'b1;
            state_nxt = SETTLE;
          end else begin
            reject    = 1'b1;
            state_nxt = WAIT_MIN;
          end
        end
      end
      SETTLE: begin
        settle_dec = 1'b1;
        if (settle_done) begin
          state_nxt = WAIT_MIN;
        end
      end
      default: begin
        state_nxt = WAIT_MIN;
      end
    endcase
  end

  // Settle window: loaded at the commit edge, so the mask covers exactly
  // settle_cycles cycles after that edge.
  ovl_delta_cfg_settle_ctr u_settle_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (commit),
    .load_val (SETTLE_INIT),
    .dec      (settle_dec),
    .done     (settle_done)
  );

  // Limits, shadow, error pulse and mask
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_min        <= '0;
      min               <= '0;
      max               <= '0;
      cfg_err           <= 1'b0;
      prevConfigInvalid <= 1'b1;
    end else begin
      cfg_err <= reject;
      if ((state == WAIT_MIN) && cfg_valid) begin
        shadow_min <= cfg_data;
      end
      if (commit) begin
        min               <= shadow_min;
        max               <= cfg_data;
        prevConfigInvalid <= 1'b1;
      end else if ((state == SETTLE) && settle_done) begin
        prevConfigInvalid <= 1'b0;
      end
    end
  end

`ifdef OVL_DELTA_CFG_FIRECNT_EN
  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (v == '1) ? v : (v + cnt_width'(1));
  endfunction

  logic [cnt_width-1:0] fire_cnt;

  // Clear wins over increment; fires while masked are not counted.
  always_ff @(posedge clk) begin
    if (rst || fire_clr) begin
      fire_cnt <= '0;
    end else if (fire_in && !prevConfigInvalid) begin
      fire_cnt <= sat_inc(fire_cnt);
    end
  end

  assign fire_count = fire_cnt;
`else
  logic unused_fire;
  assign unused_fire = fire_in ^ fire_clr;
  assign fire_count  = '0;
`endif

endmodule
